branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped BTB/BHT entries (power of two).
REQ-002 SHALL have parameter PC_W, default 64, program-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port pc_if  input  PC_W  fetch-stage PC to predict.
REQ-006 SHALL have port pred_taken_if  output  1  fetch-stage prediction: taken.
REQ-007 SHALL have port pred_target_if  output  PC_W  predicted next PC: BTB target if taken, else pc_if+4.
REQ-008 SHALL have port exe_valid  input  1  EXE stage holds a real instruction.
REQ-009 SHALL have port is_branch_exe  input  1  EXE instruction is a conditional branch.
REQ-010 SHALL have port is_jump_exe  input  1  EXE instruction is jal/jalr.
REQ-011 SHALL have port pc_exe  input  PC_W  EXE instruction PC.
REQ-012 SHALL have port br_taken_exe  input  1  resolved branch outcome (ignored for jumps; jumps are always taken).
REQ-013 SHALL have port target_exe  input  PC_W  resolved target.
REQ-014 SHALL have port pred_taken_exe, pred_target_exe  input  1, PC_W  prediction carried down the pipeline with the instruction.
REQ-015 SHALL have port stall_exe  input  1  EXE/MEM register held this cycle.
REQ-016 SHALL have port flush_exe  input  1  mode switch; EXE contents discarded.
REQ-017 SHALL have port error_prediction  output  1  misprediction detected in EXE; feeds the hazard controller.
REQ-018 SHALL have port correct_pc  output  PC_W  redirect PC when error_prediction=1.
REQ-019 SHALL have port perf_branches, perf_mispredicts  output  32 each  performance counters.

Function
REQ-020 SHALL index with pc[log2(ENTRIES)+1:2] and tag with pc[PC_W-1:log2(ENTRIES)+2]; PCs are 4-byte aligned.
REQ-021 SHALL drive pred_taken_if combinationally = entry valid & tag match & counter[1]; no bypass of a same-cycle write (lookup sees pre-edge contents).
REQ-022 SHALL define resolved taken T = is_jump_exe | (is_branch_exe & br_taken_exe).
REQ-023 SHALL assert error_prediction combinationally = exe_valid & ~flush_exe & ((T != pred_taken_exe) | (T & target_exe != pred_target_exe)); this includes non-branch instructions predicted taken (stale entry).
REQ-024 SHALL drive correct_pc = T ? target_exe : pc_exe+4 (PC_W-bit wraparound).
REQ-025 SHALL hold error_prediction at its level while stall_exe=1; table and counters update only on fire = exe_valid & ~stall_exe & ~flush_exe, so each instruction updates exactly once.
REQ-026 SHALL, on fire with hit & branch/jump: counter saturating +1 if T (max 2'b11), -1 if ~T (min 2'b00); jump forces 2'b11; target overwritten with target_exe if T.
REQ-027 SHALL, on fire with miss & T: allocate/replace entry with valid=1, new tag, target_exe, counter 2'b10 (jump: 2'b11); on miss & ~T: no write.
REQ-028 SHALL, on fire with hit on a non-branch/non-jump instruction, clear that entry's valid bit.
REQ-029 SHALL increment perf_branches on every fire with is_branch_exe|is_jump_exe, and perf_mispredicts on every fire with error_prediction; both wrap modulo 2^32.

Reset
REQ-030 SHALL, while rstn=0, clear all valid bits, set all counters to 2'b01, zero both perf counters; outputs: pred_taken_if=0, pred_target_if=pc_if+4.
REQ-031 SHALL apply reset asynchronously mid-update; a fire coincident with reset deassertion edge has no effect.

Structure
REQ-032 SHALL place PC_W default, counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the index/tag width functions in a shared package.
REQ-033 SHALL isolate the storage array plus read/write ports in one sub-module bp_btb_table.

Verification
REQ-034 Reset, then pc_if=0x1000 -> pred_taken_if=0, pred_target_if=0x1004.
REQ-035 Fire taken branch pc_exe=0x1000, target 0x1040, pred 0 -> error_prediction=1, correct_pc=0x1040; next cycle pc_if=0x1000 -> pred_taken_if=1, target 0x1040.
REQ-036 Same branch not taken twice from WT -> first: mispredict, counter WNT; second: predicted not-taken, no error; perf_mispredicts=2, perf_branches=3.
REQ-037 Mispredicted branch with stall_exe=1 for 3 cycles -> error_prediction high all 4 cycles; counter and perf counters change once.
REQ-038 Aliasing: pc 0x1000 then 0x1040 (ENTRIES=16), both taken -> second replaces entry; lookup 0x1000 now misses.
REQ-039 flush_exe=1 with mispredicted branch -> error_prediction=0, no table or counter update.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: default PC width, 2-bit
// saturating counter encoding, table geometry helpers.
package branch_predictor_pkg;

  localparam int PC_W_DEFAULT = 64;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Bits [1:0] are dropped because PCs are word aligned.
  function automatic int tag_w(input int pc_w, input int entries);
    return pc_w - $clog2(entries) - 2;
  endfunction

  function automatic ctr_e ctr_update(input ctr_e c, input logic taken);
    case (c)
      CTR_SNT: return taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: return taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  return taken ? CTR_ST  : CTR_WNT;
      default: return taken ? CTR_ST  : CTR_WT;
    endcase
  endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped BTB/BHT storage: two combinational read ports (fetch, exe)
// and one full-entry write port.
module bp_btb_table
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 58,
  parameter int PC_W    = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] i_rd_idx_a,
  output logic             o_valid_a,
  output logic [TAG_W-1:0] o_tag_a,
  output logic [PC_W-1:0]  o_target_a,
  output ctr_e             o_ctr_a,
  input  logic [IDX_W-1:0] i_rd_idx_b,
  output logic             o_valid_b,
  output logic [TAG_W-1:0] o_tag_b,
  output logic [PC_W-1:0]  o_target_b,
  output ctr_e             o_ctr_b,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_valid,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic [PC_W-1:0]  i_wr_target,
  input  ctr_e             i_wr_ctr
);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [PC_W-1:0]  r_target [ENTRIES];
  ctr_e             r_ctr    [ENTRIES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (i_we) begin
      r_valid[i_wr_idx]  <= i_wr_valid;
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
      r_ctr[i_wr_idx]    <= i_wr_ctr;
    end
  end

  // Reads return pre-edge contents; no write bypass.
  assign o_valid_a  = r_valid[i_rd_idx_a];
  assign o_tag_a    = r_tag[i_rd_idx_a];
  assign o_target_a = r_target[i_rd_idx_a];
  assign o_ctr_a    = r_ctr[i_rd_idx_a];
  assign o_valid_b  = r_valid[i_rd_idx_b];
  assign o_tag_b    = r_tag[i_rd_idx_b];
  assign o_target_b = r_target[i_rd_idx_b];
  assign o_ctr_b    = r_ctr[i_rd_idx_b];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage BTB/BHT predictor with EXE-stage misprediction detection,
// table training and performance counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [PC_W-1:0] pc_if,
  output logic            pred_taken_if,
  output logic [PC_W-1:0] pred_target_if,
  input  logic            exe_valid,
  input  logic            is_branch_exe,
  input  logic            is_jump_exe,
  input  logic [PC_W-1:0] pc_exe,
  input  logic            br_taken_exe,
  input  logic [PC_W-1:0] target_exe,
  input  logic            pred_taken_exe,
  input  logic [PC_W-1:0] pred_target_exe,
  input  logic            stall_exe,
  input  logic            flush_exe,
  output logic            error_prediction,
  output logic [PC_W-1:0] correct_pc,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(PC_W, ENTRIES);
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic [IDX_W-1:0] w_idx_if, w_idx_exe;
  logic [TAG_W-1:0] w_tag_if, w_tag_exe;
  logic             w_valid_a, w_valid_b;
  logic [TAG_W-1:0] w_tag_a, w_tag_b;
  logic [PC_W-1:0]  w_target_a, w_target_b;
  ctr_e             w_ctr_a, w_ctr_b;
  logic             w_taken, w_ctrl, w_fire, w_hit_exe;
  logic             w_we, w_wr_valid;
  logic [PC_W-1:0]  w_wr_target;
  ctr_e             w_wr_ctr;
  logic [31:0]      r_perf_branches, r_perf_mispredicts;
  logic             w_unused_pc_bits;

  assign w_idx_if  = pc_if[IDX_W+1:2];
  assign w_tag_if  = pc_if[PC_W-1:IDX_W+2];
  assign w_idx_exe = pc_exe[IDX_W+1:2];
  assign w_tag_exe = pc_exe[PC_W-1:IDX_W+2];
  assign w_unused_pc_bits = ^{pc_if[1:0], pc_exe[1:0]};

  bp_btb_table #(
    .ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)
  ) u_table (
    .clk         (clk),
    .rstn        (rstn),
    .i_rd_idx_a  (w_idx_if),
    .o_valid_a   (w_valid_a),
    .o_tag_a     (w_tag_a),
    .o_target_a  (w_target_a),
    .o_ctr_a     (w_ctr_a),
    .i_rd_idx_b  (w_idx_exe),
    .o_valid_b   (w_valid_b),
    .o_tag_b     (w_tag_b),
    .o_target_b  (w_target_b),
    .o_ctr_b     (w_ctr_b),
    .i_we        (w_we),
    .i_wr_idx    (w_idx_exe),
    .i_wr_valid  (w_wr_valid),
    .i_wr_tag    (w_tag_exe),
    .i_wr_target (w_wr_target),
    .i_wr_ctr    (w_wr_ctr)
  );

  assign pred_taken_if  = w_valid_a & (w_tag_a == w_tag_if) & w_ctr_a[1];
  assign pred_target_if = pred_taken_if ? w_target_a : pc_if + PC_STEP;

  assign w_taken   = is_jump_exe | (is_branch_exe & br_taken_exe);
  assign w_ctrl    = is_branch_exe | is_jump_exe;
  assign w_fire    = exe_valid & ~stall_exe & ~flush_exe;
  assign w_hit_exe = w_valid_b & (w_tag_b == w_tag_exe);

  assign error_prediction = exe_valid & ~flush_exe &
                            ((w_taken != pred_taken_exe) |
                             (w_taken & (target_exe != pred_target_exe)));
  assign correct_pc = w_taken ? target_exe : pc_exe + PC_STEP;

  // A hit on a non-control instruction means a stale entry; invalidate it.
  always_comb begin
    w_we        = 1'b0;
    w_wr_valid  = 1'b1;
    w_wr_target = w_target_b;
    w_wr_ctr    = w_ctr_b;
    if (w_fire) begin
      if (w_hit_exe && w_ctrl) begin
        w_we     = 1'b1;
        w_wr_ctr = is_jump_exe ? CTR_ST : ctr_update(w_ctr_b, w_taken);
        if (w_taken) w_wr_target = target_exe;
      end else if (w_hit_exe) begin
        w_we       = 1'b1;
        w_wr_valid = 1'b0;
      end else if (w_taken) begin
        w_we        = 1'b1;
        w_wr_target = target_exe;
        w_wr_ctr    = is_jump_exe ? CTR_ST : CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else if (w_fire) begin
      if (w_ctrl)           r_perf_branches    <= r_perf_branches + 32'd1;
      if (error_prediction) r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor (ENTRIES=16, PC_W=64).
module tb_branch_predictor;

  logic        clk;
  logic        rstn;
  logic [63:0] pc_if;
  logic        pred_taken_if;
  logic [63:0] pred_target_if;
  logic        exe_valid, is_branch_exe, is_jump_exe, br_taken_exe;
  logic [63:0] pc_exe, target_exe, pred_target_exe;
  logic        pred_taken_exe, stall_exe, flush_exe;
  logic        error_prediction;
  logic [63:0] correct_pc;
  logic [31:0] perf_branches, perf_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] pc_if;
    logic        ev, br, jmp;
    logic [63:0] pc_exe;
    logic        tk;
    logic [63:0] tgt;
    logic        ptk;
    logic [63:0] ptgt;
    logic        stall, flush;
    logic        e_pt;
    logic [63:0] e_ptgt;
    logic        e_err;
    logic [63:0] e_cpc;
    logic [31:0] e_pbr, e_pmis;
  } vec_t;

  vec_t vq[$];

  branch_predictor dut (
    .clk              (clk),
    .rstn             (rstn),
    .pc_if            (pc_if),
    .pred_taken_if    (pred_taken_if),
    .pred_target_if   (pred_target_if),
    .exe_valid        (exe_valid),
    .is_branch_exe    (is_branch_exe),
    .is_jump_exe      (is_jump_exe),
    .pc_exe           (pc_exe),
    .br_taken_exe     (br_taken_exe),
    .target_exe       (target_exe),
    .pred_taken_exe   (pred_taken_exe),
    .pred_target_exe  (pred_target_exe),
    .stall_exe        (stall_exe),
    .flush_exe        (flush_exe),
    .error_prediction (error_prediction),
    .correct_pc       (correct_pc),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  task automatic v(input logic [63:0] pcf, input logic ev, input logic br, input logic jmp,
                   input logic [63:0] pce, input logic tk, input logic [63:0] tgt,
                   input logic ptk, input logic [63:0] ptgt, input logic st, input logic fl,
                   input logic e_pt, input logic [63:0] e_ptgt, input logic e_err,
                   input logic [63:0] e_cpc, input logic [31:0] e_pbr, input logic [31:0] e_pmis);
    vec_t r;
    r.pc_if = pcf; r.ev = ev; r.br = br; r.jmp = jmp; r.pc_exe = pce; r.tk = tk;
    r.tgt = tgt; r.ptk = ptk; r.ptgt = ptgt; r.stall = st; r.flush = fl;
    r.e_pt = e_pt; r.e_ptgt = e_ptgt; r.e_err = e_err; r.e_cpc = e_cpc;
    r.e_pbr = e_pbr; r.e_pmis = e_pmis;
    vq.push_back(r);
  endtask

  // Idle EXE slot: pc_exe=0, nothing resolved, so correct_pc=4 and no error.
  task automatic idle(input logic [63:0] pcf, input logic e_pt, input logic [63:0] e_ptgt,
                      input logic [31:0] e_pbr, input logic [31:0] e_pmis);
    v(pcf, 0, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0, 0, e_pt, e_ptgt, 0, 64'h4, e_pbr, e_pmis);
  endtask

  // Driver
  task automatic drive(input vec_t r);
    pc_if = r.pc_if; exe_valid = r.ev; is_branch_exe = r.br; is_jump_exe = r.jmp;
    pc_exe = r.pc_exe; br_taken_exe = r.tk; target_exe = r.tgt;
    pred_taken_exe = r.ptk; pred_target_exe = r.ptgt;
    stall_exe = r.stall; flush_exe = r.flush;
  endtask

  task automatic drive_idle(input logic [63:0] pcf);
    vec_t r;
    r = '{default: '0};
    r.pc_if = pcf;
    drive(r);
  endtask

  initial begin
    rstn = 1'b0;
    drive_idle(64'h1000);

    // Each row: inputs for one cycle, outputs expected from pre-edge state.
    idle(64'h1000, 0, 64'h1004, 0, 0);                                                          // 0
    v(64'h1000, 1,1,0, 64'h1000,1,64'h1040, 0,64'h1004, 0,0, 0,64'h1004, 1,64'h1040, 0,0);      // 1
    idle(64'h1000, 1, 64'h1040, 1, 1);                                                          // 2
    v(64'h1000, 1,1,0, 64'h1000,0,64'h1040, 1,64'h1040, 0,0, 1,64'h1040, 1,64'h1004, 1,1);      // 3
    v(64'h1000, 1,1,0, 64'h1000,0,64'h1040, 0,64'h1004, 0,0, 0,64'h1004, 0,64'h1004, 2,2);      // 4
    idle(64'h1000, 0, 64'h1004, 3, 2);                                                          // 5
    for (int i = 0; i < 3; i++)                                                                 // 6-8
      v(64'h1000, 1,1,0, 64'h1000,1,64'h1040, 0,64'h1004, 1,0, 0,64'h1004, 1,64'h1040, 3,2);
    v(64'h1000, 1,1,0, 64'h1000,1,64'h1040, 0,64'h1004, 0,0, 0,64'h1004, 1,64'h1040, 3,2);      // 9
    idle(64'h1000, 0, 64'h1004, 4, 3);                                                          // 10
    v(64'h1000, 1,1,0, 64'h1000,1,64'h1040, 0,64'h1004, 0,1, 0,64'h1004, 0,64'h1040, 4,3);      // 11
    idle(64'h1000, 0, 64'h1004, 4, 3);                                                          // 12
    v(64'h1000, 1,1,0, 64'h1000,1,64'h1040, 0,64'h1004, 0,0, 0,64'h1004, 1,64'h1040, 4,3);      // 13
    idle(64'h1000, 1, 64'h1040, 5, 4);                                                          // 14
    v(64'h1040, 1,1,0, 64'h1040,1,64'h2000, 0,64'h1044, 0,0, 0,64'h1044, 1,64'h2000, 5,4);      // 15
    idle(64'h1000, 0, 64'h1004, 6, 5);                                                          // 16
    idle(64'h1040, 1, 64'h2000, 6, 5);                                                          // 17
    v(64'h2008, 1,0,1, 64'h2008,0,64'h3000, 0,64'h200c, 0,0, 0,64'h200c, 1,64'h3000, 6,5);      // 18
    v(64'h2008, 1,0,1, 64'h2008,0,64'h3000, 1,64'h3000, 0,0, 1,64'h3000, 0,64'h3000, 7,6);      // 19
    v(64'h2008, 1,0,1, 64'h2008,0,64'h3100, 1,64'h3000, 0,0, 1,64'h3000, 1,64'h3100, 8,6);      // 20
    v(64'h2008, 1,0,0, 64'h2008,0,64'h0,    1,64'h3100, 0,0, 1,64'h3100, 1,64'h200c, 9,7);      // 21
    idle(64'h2008, 0, 64'h200c, 9, 8);                                                          // 22
    v(64'h3004, 1,1,0, 64'h3004,0,64'h3100, 0,64'h3008, 0,0, 0,64'h3008, 0,64'h3008, 9,8);      // 23
    idle(64'h3004, 0, 64'h3008, 10, 8);                                                         // 24
    v(64'hFFFF_FFFF_FFFF_FFFC, 1,1,0, 64'hFFFF_FFFF_FFFF_FFFC,0,64'h10, 0,64'h0, 0,0,
      0,64'h0, 0,64'h0, 10,8);                                                                  // 25
    v(64'h1000, 0,1,0, 64'h0,1,64'h1040, 1,64'h1040, 0,0, 0,64'h1004, 0,64'h1040, 11,8);        // 26

    // Reset state, checked while reset is held.
    #1;
    check("rst_pred_taken", -1, 64'(pred_taken_if), 64'h0);
    check("rst_pred_target", -1, pred_target_if, 64'h1004);
    check("rst_perf_br", -1, 64'(perf_branches), 64'h0);
    check("rst_perf_mis", -1, 64'(perf_mispredicts), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vq[i]);
      @(negedge clk);
      check("pred_taken_if", i, 64'(pred_taken_if), 64'(vq[i].e_pt));
      check("pred_target_if", i, pred_target_if, vq[i].e_ptgt);
      check("error_prediction", i, 64'(error_prediction), 64'(vq[i].e_err));
      check("correct_pc", i, correct_pc, vq[i].e_cpc);
      check("perf_branches", i, 64'(perf_branches), 64'(vq[i].e_pbr));
      check("perf_mispredicts", i, 64'(perf_mispredicts), 64'(vq[i].e_pmis));
    end

    // Asynchronous reset mid-run: entry for 0x1040 is valid, perf counters nonzero.
    @(posedge clk);
    #1;
    drive(vq[15]);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_pred_taken", 100, 64'(pred_taken_if), 64'h0);
    check("async_rst_pred_target", 100, pred_target_if, 64'h1044);
    check("async_rst_perf_br", 100, 64'(perf_branches), 64'h0);
    check("async_rst_perf_mis", 100, 64'(perf_mispredicts), 64'h0);
    @(posedge clk);
    @(negedge clk);
    drive_idle(64'h1040);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_pred_taken", 101, 64'(pred_taken_if), 64'h0);
    check("post_rst_pred_target", 101, pred_target_if, 64'h1044);
    check("post_rst_perf_br", 101, 64'(perf_branches), 64'h0);
    check("post_rst_perf_mis", 101, 64'(perf_mispredicts), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
